// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a requester and apb_slave_regfile.
// Width parameters must match those of the attached apb_slave_regfile.
interface apb_slave_regfile_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) ();
   logic                      psel;
   logic                      penable;
   logic [ADDR_WIDTH-1:0]     paddr;
   logic                      pwrite;
   logic [DATA_WIDTH-1:0]     pwdata;
   logic [DATA_WIDTH/8-1:0]   pstrb;
   logic                      pready;
   logic                      pslverr;
   logic [DATA_WIDTH-1:0]     prdata;

   modport master (
      output psel, penable, paddr, pwrite, pwdata, pstrb,
      input  pready, pslverr, prdata
   );

   modport slave (
      input  psel, penable, paddr, pwrite, pwdata, pstrb,
      output pready, pslverr, prdata
   );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer backed by a bank of byte-strobed read/write registers,
// with configurable wait states, decode errors and abort on psel drop.
module apb_slave_regfile #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_STATES = 0
) (
   input logic                pclk,
   input logic                presetn,
   apb_slave_regfile_if.slave apb
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int OFS        = $clog2(STRB_WIDTH);
   localparam int IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << OFS) - 1);
   localparam logic [ADDR_WIDTH:0]   NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  state_r;
   logic [3:0]              cnt_r;
   logic [IDX_WIDTH-1:0]    idx_r;
   logic                    write_r;
   logic                    err_r;
   logic [DATA_WIDTH-1:0]   wdata_r;
   logic [STRB_WIDTH-1:0]   strb_r;
   logic                    pready_r;
   logic                    pslverr_r;
   logic [DATA_WIDTH-1:0]   prdata_r;
   logic [DATA_WIDTH-1:0]   regs_r [NUM_REGS];

   logic [ADDR_WIDTH-1:0]   dec_full_idx_s;
   logic [IDX_WIDTH-1:0]    dec_idx_s;
   logic                    dec_err_s;
   logic [IDX_WIDTH-1:0]    rd_idx_s;
   logic                    rd_err_s;
   logic                    rd_write_s;
   logic [DATA_WIDTH-1:0]   rd_word_s;
   logic                    commit_s;

   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [STRB_WIDTH-1:0] strb
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_word;
      for (int b = 0; b < STRB_WIDTH; b++) begin
         if (strb[b]) begin
            res[8*b +: 8] = new_word[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_word[8*b +: 8];
         end
      end
      return res;
   endfunction

   // Decode the address currently on the bus into a register index and error flag
   always_comb begin
      dec_full_idx_s = apb.paddr >> OFS;
      dec_idx_s      = dec_full_idx_s[IDX_WIDTH-1:0];
      dec_err_s      = ((apb.paddr & ALIGN_MASK) != {ADDR_WIDTH{1'b0}}) ||
                       ({1'b0, dec_full_idx_s} >= NUM_REGS_W);
   end

   // Read data source: live decode when entering DONE straight from IDLE, else latched request
   always_comb begin
      rd_idx_s   = idx_r;
      rd_err_s   = err_r;
      rd_write_s = write_r;
      if (state_r == ST_IDLE) begin
         rd_idx_s   = dec_idx_s;
         rd_err_s   = dec_err_s;
         rd_write_s = apb.pwrite;
      end else begin
         rd_idx_s   = idx_r;
         rd_err_s   = err_r;
         rd_write_s = write_r;
      end
      if (rd_err_s || rd_write_s) begin
         rd_word_s = {DATA_WIDTH{1'b0}};
      end else begin
         rd_word_s = regs_r[rd_idx_s];
      end
   end

   // A write commits on the edge ending DONE, unless the master dropped psel
   always_comb begin
      commit_s = (state_r == ST_DONE) && apb.psel && write_r && !err_r;
   end

   // Transfer sequencing with registered bus responses
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 4'd0;
         idx_r     <= {IDX_WIDTH{1'b0}};
         write_r   <= 1'b0;
         err_r     <= 1'b0;
         wdata_r   <= {DATA_WIDTH{1'b0}};
         strb_r    <= {STRB_WIDTH{1'b0}};
         pready_r  <= 1'b0;
         pslverr_r <= 1'b0;
         prdata_r  <= {DATA_WIDTH{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               pready_r  <= 1'b0;
               pslverr_r <= 1'b0;
               prdata_r  <= {DATA_WIDTH{1'b0}};
               if (apb.psel && !apb.penable) begin
                  idx_r   <= dec_idx_s;
                  write_r <= apb.pwrite;
                  err_r   <= dec_err_s;
                  wdata_r <= apb.pwdata;
                  strb_r  <= apb.pstrb;
                  if (WAIT_STATES == 0) begin
                     state_r   <= ST_DONE;
                     pready_r  <= 1'b1;
                     pslverr_r <= dec_err_s;
                     prdata_r  <= rd_word_s;
                  end else begin
                     state_r <= ST_WAIT;
                     cnt_r   <= WAIT_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               pready_r  <= 1'b0;
               pslverr_r <= 1'b0;
               prdata_r  <= {DATA_WIDTH{1'b0}};
               if (!apb.psel) begin
                  state_r <= ST_IDLE;
               end else if (cnt_r == 4'd0) begin
                  state_r   <= ST_DONE;
                  pready_r  <= 1'b1;
                  pslverr_r <= err_r;
                  prdata_r  <= rd_word_s;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            ST_DONE: begin
               // Completion and abort both return to IDLE; only the register update differs
               state_r   <= ST_IDLE;
               pready_r  <= 1'b0;
               pslverr_r <= 1'b0;
               prdata_r  <= {DATA_WIDTH{1'b0}};
            end
            default: begin
               state_r   <= ST_IDLE;
               cnt_r     <= 4'd0;
               pready_r  <= 1'b0;
               pslverr_r <= 1'b0;
               prdata_r  <= {DATA_WIDTH{1'b0}};
            end
         endcase
      end
   end

   // Register bank storage with per-byte write strobes
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (commit_s) begin
         regs_r[idx_r] <= merge_bytes(regs_r[idx_r], wdata_r, strb_r);
      end
   end

   assign apb.pready  = pready_r;
   assign apb.pslverr = pslverr_r;
   assign apb.prdata  = prdata_r;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: one instance with no wait states, one with three,
// checked every cycle against a transaction-level register model.
`timescale 1ns/1ps
module tb_apb_slave_regfile;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int NR = 16;

   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   logic          presetn_d [2];
   logic          psel_d    [2];
   logic          penable_d [2];
   logic [AW-1:0] paddr_d   [2];
   logic          pwrite_d  [2];
   logic [DW-1:0] pwdata_d  [2];
   logic [SW-1:0] pstrb_d   [2];
   logic          rdy_q     [2];
   logic          err_q     [2];
   logic [DW-1:0] rd_q      [2];
   logic          exp_rdy   [2];
   logic          exp_err   [2];
   logic [DW-1:0] exp_rd    [2];
   logic [DW-1:0] model     [2][NR];
   int            n_pass  = 0;
   int            n_total = 0;
   bit            chk_en  = 1'b0;

   apb_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
   apb_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

   assign bus0.psel    = psel_d[0];
   assign bus0.penable = penable_d[0];
   assign bus0.paddr   = paddr_d[0];
   assign bus0.pwrite  = pwrite_d[0];
   assign bus0.pwdata  = pwdata_d[0];
   assign bus0.pstrb   = pstrb_d[0];
   assign rdy_q[0]     = bus0.pready;
   assign err_q[0]     = bus0.pslverr;
   assign rd_q[0]      = bus0.prdata;
   assign bus1.psel    = psel_d[1];
   assign bus1.penable = penable_d[1];
   assign bus1.paddr   = paddr_d[1];
   assign bus1.pwrite  = pwrite_d[1];
   assign bus1.pwdata  = pwdata_d[1];
   assign bus1.pstrb   = pstrb_d[1];
   assign rdy_q[1]     = bus1.pready;
   assign err_q[1]     = bus1.pslverr;
   assign rd_q[1]      = bus1.prdata;

   apb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(0)) dut0 (
      .pclk(pclk), .presetn(presetn_d[0]), .apb(bus0));
   apb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(3)) dut1 (
      .pclk(pclk), .presetn(presetn_d[1]), .apb(bus1));

   task automatic check(input string name, input int k, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_total++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s dut%0d t=%0t: got %h, expected %h", name, k, $time, act, req);
      end
   endtask

   // Every cycle, both instances' outputs must match the model's expectation
   always @(negedge pclk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            check("pready", k, DW'(rdy_q[k]), DW'(exp_rdy[k]));
            check("pslverr", k, DW'(err_q[k]), DW'(exp_err[k]));
            check("prdata", k, rd_q[k], exp_rd[k]);
         end
      end
   end

   // One transfer, starting in the current (idle) cycle; ends one cycle after DONE.
   task automatic xfer(input int k, input logic [AW-1:0] addr, input logic wr,
                       input logic [DW-1:0] wd, input logic [SW-1:0] st,
                       input int abort_cyc, input bit rst_done,
                       output logic [DW-1:0] rd_cap, output logic err_cap, output int lat);
      int ws;
      int idx;
      bit err;
      bit aborted;
      ws      = (k == 0) ? 0 : 3;
      idx     = int'(addr[AW-1:2]);
      err     = (addr[1:0] != 2'b00) || (idx >= NR);
      aborted = 1'b0;
      lat     = -1;
      rd_cap  = '0;
      err_cap = 1'b0;
      psel_d[k] = 1'b1; penable_d[k] = 1'b0; paddr_d[k] = addr;
      pwrite_d[k] = wr; pwdata_d[k] = wd; pstrb_d[k] = st;
      exp_rdy[k] = 1'b0; exp_err[k] = 1'b0; exp_rd[k] = '0;
      for (int c = 1; c <= ws + 1 && !aborted; c++) begin
         @(posedge pclk); #1;
         penable_d[k] = 1'b1;
         if (c == ws + 1) begin
            exp_rdy[k] = 1'b1;
            exp_err[k] = err;
            exp_rd[k]  = (wr || err) ? '0 : model[k][idx];
            if (rst_done) presetn_d[k] = 1'b0;
         end
         if (c == abort_cyc) begin
            psel_d[k] = 1'b0; penable_d[k] = 1'b0; aborted = 1'b1;
         end
         @(negedge pclk);
         if (rdy_q[k] === 1'b1 && lat < 0) begin
            lat = c; rd_cap = rd_q[k]; err_cap = err_q[k];
         end
      end
      @(posedge pclk); #1;
      if (rst_done) begin
         for (int i = 0; i < NR; i++) model[k][i] = '0;
         presetn_d[k] = 1'b1;
      end else if (!aborted && wr && !err) begin
         for (int b = 0; b < SW; b++) begin
            if (st[b]) model[k][idx][8*b +: 8] = wd[8*b +: 8];
         end
      end
      psel_d[k] = 1'b0; penable_d[k] = 1'b0;
      exp_rdy[k] = 1'b0; exp_err[k] = 1'b0; exp_rd[k] = '0;
   endtask

   initial begin
      logic [DW-1:0] rd;
      logic          e;
      int            lat;
      for (int k = 0; k < 2; k++) begin
         presetn_d[k] = 1'b0; psel_d[k] = 1'b0; penable_d[k] = 1'b0;
         paddr_d[k] = '0; pwrite_d[k] = 1'b0; pwdata_d[k] = '0; pstrb_d[k] = '0;
         exp_rdy[k] = 1'b0; exp_err[k] = 1'b0; exp_rd[k] = '0;
         for (int i = 0; i < NR; i++) model[k][i] = '0;
      end
      repeat (2) @(posedge pclk);
      #1;
      chk_en = 1'b1;
      presetn_d[0] = 1'b1;
      presetn_d[1] = 1'b1;

      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NR; i++) begin
            xfer(k, AW'(i * 4), 1'b0, '0, 4'h0, -1, 1'b0, rd, e, lat);
            check("rst_read", k, rd, 32'h0000_0000);
         end
         check("rst_lat", k, DW'(lat), (k == 0) ? 32'd1 : 32'd4);

         xfer(k, 8'h08, 1'b1, 32'hDEAD_BEEF, 4'hF, -1, 1'b0, rd, e, lat);
         check("wr_lat", k, DW'(lat), (k == 0) ? 32'd1 : 32'd4);
         xfer(k, 8'h08, 1'b0, '0, 4'h0, -1, 1'b0, rd, e, lat);
         check("raw_data", k, rd, 32'hDEAD_BEEF);
         check("raw_err", k, DW'(e), 32'd0);

         xfer(k, 8'h04, 1'b1, 32'h1122_3344, 4'hF, -1, 1'b0, rd, e, lat);
         xfer(k, 8'h04, 1'b1, 32'hAABB_CCDD, 4'h5, -1, 1'b0, rd, e, lat);
         xfer(k, 8'h04, 1'b0, '0, 4'h0, -1, 1'b0, rd, e, lat);
         check("strb_data", k, rd, 32'h11BB_33DD);

         xfer(k, 8'h02, 1'b1, 32'h1234_5678, 4'hF, -1, 1'b0, rd, e, lat);
         check("misalign_err", k, DW'(e), 32'd1);
         xfer(k, 8'h00, 1'b0, '0, 4'h0, -1, 1'b0, rd, e, lat);
         check("misalign_noupd", k, rd, 32'h0000_0000);

         xfer(k, 8'h40, 1'b0, '0, 4'h0, -1, 1'b0, rd, e, lat);
         check("range_err", k, DW'(e), 32'd1);
         check("range_data", k, rd, 32'h0000_0000);

         xfer(k, 8'h08, 1'b1, 32'h5555_5555, 4'h0, -1, 1'b0, rd, e, lat);
         check("nostrb_err", k, DW'(e), 32'd0);
         xfer(k, 8'h08, 1'b0, '0, 4'h0, -1, 1'b0, rd, e, lat);
         check("nostrb_data", k, rd, 32'hDEAD_BEEF);

         xfer(k, 8'h0C, 1'b1, 32'h0102_0304, 4'hF, -1, 1'b0, rd, e, lat);
         xfer(k, 8'h0C, 1'b1, 32'hCAFE_F00D, 4'hF, (k == 0) ? 1 : 2, 1'b0, rd, e, lat);
         if (k == 1) check("abort_noready", k, DW'(lat), 32'hFFFF_FFFF);
         repeat (2) begin @(posedge pclk); #1; end
         xfer(k, 8'h0C, 1'b0, '0, 4'h0, -1, 1'b0, rd, e, lat);
         check("abort_data", k, rd, 32'h0102_0304);

         xfer(k, 8'h00, 1'b1, 32'hFFFF_FFFF, 4'hF, -1, 1'b1, rd, e, lat);
         xfer(k, 8'h00, 1'b0, '0, 4'h0, -1, 1'b0, rd, e, lat);
         check("rstmid_data", k, rd, 32'h0000_0000);
         xfer(k, 8'h08, 1'b0, '0, 4'h0, -1, 1'b0, rd, e, lat);
         check("rstmid_clear", k, rd, 32'h0000_0000);
         repeat (2) begin @(posedge pclk); #1; end
      end

      @(posedge pclk); #1;
      @(negedge pclk); #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
